// File: rtl/fdiv_newton_ctrl_if.sv
// Request/response handshake bundle for the fdiv_newton_ctrl divider front end.
interface fdiv_newton_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  rm;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic [4:0]  flags;

    modport master (
        output in_valid, op_a, op_b, rm, res_ready,
        input  in_ready, res_valid, result, flags
    );

    modport slave (
        input  in_valid, op_a, op_b, rm, res_ready,
        output in_ready, res_valid, result, flags
    );
endinterface

// File: rtl/fdiv_newton_ctrl.sv
// Single-precision divide controller around a fixed-latency iterative mantissa core.
// Optional macro FDIV_RMODE_EN: honour rm for all four rounding modes (else RNE only).
module fdiv_newton_ctrl (
    input  logic               clk,
    input  logic               clrn,
    fdiv_newton_ctrl_if.slave  bus,
    output logic [23:0]        core_a,
    output logic [23:0]        core_b,
    output logic               core_fdiv,
    output logic               core_ena,
    input  logic [31:0]        core_q,
    input  logic               core_busy
);
    typedef enum logic [2:0] {IDLE, START, ITER, DRAIN, DONE} state_t;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [7:0]  ea, eb;
    logic        sign_q;
    logic [31:0] result_q;
    logic [4:0]  flags_q;
`ifdef FDIV_RMODE_EN
    logic [1:0]  rm_q;
`endif

    fp32_t a, b;
    logic  accept, sgn;
    logic  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, special;
    logic [31:0] sp_res;
    logic [4:0]  sp_flags;

    assign a      = bus.op_a;
    assign b      = bus.op_b;
    assign accept = bus.in_valid & bus.in_ready;
    assign sgn    = a.sign ^ b.sign;

    // Exponent 0 is zero regardless of fraction: denormal inputs are flushed.
    assign a_zero  = (a.exp == 8'h00);
    assign b_zero  = (b.exp == 8'h00);
    assign a_inf   = (a.exp == 8'hFF) && (a.frac == 23'd0);
    assign b_inf   = (b.exp == 8'hFF) && (b.frac == 23'd0);
    assign a_nan   = (a.exp == 8'hFF) && (a.frac != 23'd0);
    assign b_nan   = (b.exp == 8'hFF) && (b.frac != 23'd0);
    assign a_snan  = a_nan & ~a.frac[22];
    assign b_snan  = b_nan & ~b.frac[22];
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    always_comb begin
        sp_res   = {sgn, 31'd0};
        sp_flags = 5'd0;
        if (a_nan | b_nan) begin
            sp_res   = QNAN;
            sp_flags = {a_snan | b_snan, 4'd0};
        end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
            sp_res   = QNAN;
            sp_flags = 5'b10000;
        end else if (a_inf) begin
            sp_res   = {sgn, 8'hFF, 23'd0};
        end else if (b_zero) begin
            sp_res   = {sgn, 8'hFF, 23'd0};
            sp_flags = 5'b01000;
        end
    end

    // Normalise / round the core quotient; only registered in core cycle 19.
    logic signed [9:0] e_raw, e_n, e_fin;
    logic [23:0] man;
    logic [24:0] man_rnd;
    logic [22:0] frac_o;
    logic        g, s, inc, ovf_inf;
    logic [31:0] nrm_res;
    logic [4:0]  nrm_flags;

    always_comb begin
        e_raw = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
        if (core_q[31]) begin
            man = core_q[31:8];
            g   = core_q[7];
            s   = |core_q[6:0];
            e_n = e_raw;
        end else begin
            man = core_q[30:7];
            g   = core_q[6];
            s   = |core_q[5:0];
            e_n = e_raw - 10'sd1;
        end
`ifdef FDIV_RMODE_EN
        case (rm_q)
            2'b00:   begin inc = g & (s | man[0]); ovf_inf = 1'b1;    end
            2'b01:   begin inc = 1'b0;             ovf_inf = 1'b0;    end
            2'b10:   begin inc = sign_q & (g | s);  ovf_inf = sign_q;  end
            default: begin inc = ~sign_q & (g | s); ovf_inf = ~sign_q; end
        endcase
`else
        inc     = g & (s | man[0]);
        ovf_inf = 1'b1;
`endif
        man_rnd = {1'b0, man} + {24'd0, inc};
        e_fin   = man_rnd[24] ? e_n + 10'sd1 : e_n;
        frac_o  = man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0];
        if (e_fin >= 10'sd255) begin
            nrm_res   = ovf_inf ? {sign_q, 8'hFF, 23'd0} : {sign_q, 31'h7F7F_FFFF};
            nrm_flags = 5'b00101;
        end else if (e_fin <= 10'sd0) begin
            nrm_res   = {sign_q, 31'd0};
            nrm_flags = 5'b00011;
        end else begin
            nrm_res   = {sign_q, e_fin[7:0], frac_o};
            nrm_flags = {4'd0, g | s};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = special ? DONE : START;
            START:   if (!core_busy) state_nx = ITER;
            ITER:    if (cnt == 5'd15) state_nx = DRAIN;
            DRAIN:   if (cnt == 5'd19) state_nx = DONE;
            DONE:    if (bus.res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            core_a   <= 24'd0;
            core_b   <= 24'd0;
            ea       <= 8'd0;
            eb       <= 8'd0;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
            flags_q  <= 5'd0;
`ifdef FDIV_RMODE_EN
            rm_q     <= 2'b00;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    core_a <= {1'b1, a.frac};
                    core_b <= {1'b1, b.frac};
                    ea     <= a.exp;
                    eb     <= b.exp;
                    sign_q <= sgn;
`ifdef FDIV_RMODE_EN
                    rm_q   <= bus.rm;
`endif
                    if (special) begin
                        result_q <= sp_res;
                        flags_q  <= sp_flags;
                    end
                end
                START: if (!core_busy) cnt <= 5'd1;
                ITER:  cnt <= cnt + 5'd1;
                DRAIN: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd19) begin
                        cnt      <= 5'd0;
                        result_q <= nrm_res;
                        flags_q  <= nrm_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    // in_ready is gated by clrn so it stays low while reset is held.
    assign bus.in_ready  = (state == IDLE) & clrn;
    assign bus.res_valid = (state == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign core_fdiv     = (state == START) & ~core_busy;
    assign core_ena      = (state == DRAIN) & (cnt != 5'd19);
endmodule

// File: tb/tb_fdiv_newton_ctrl.sv
// Bench for fdiv_newton_ctrl: vector table plus handshake, busy-wait and reset sequences.
module tb_fdiv_newton_ctrl;
    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [23:0] core_a, core_b;
    logic        core_fdiv, core_ena, core_busy;
    logic [31:0] core_q;

    fdiv_newton_ctrl_if bus();

    fdiv_newton_ctrl dut (
        .clk(clk), .clrn(clrn), .bus(bus),
        .core_a(core_a), .core_b(core_b), .core_fdiv(core_fdiv), .core_ena(core_ena),
        .core_q(core_q), .core_busy(core_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] res;
        logic [4:0]  flg;
        bit          special;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t sb[$];
    vec_t vt[$];

    // Core model: quotient appears only after the third ena pulse; garbage before that.
    logic [23:0] ma, mb;
    logic        model_busy, busy_force;
    int          ena_seen, fdiv_cnt, ena_cnt;

    assign core_busy = model_busy | busy_force;

    function automatic logic [31:0] quot(input logic [23:0] x, input logic [23:0] y);
        logic [55:0] num, q, r;
        num = 56'(x) << 31;
        q   = num / 56'(y);
        r   = num % 56'(y);
        return q[31:0] | {31'd0, r != 56'd0};
    endfunction

    always @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            core_q <= 32'd0; model_busy <= 1'b0; ena_seen <= 0; ma <= 24'd0; mb <= 24'd0;
        end else if (core_fdiv) begin
            ma <= core_a; mb <= core_b; model_busy <= 1'b1; ena_seen <= 0;
            core_q <= 32'hDEAD_BEEF;
        end else if (core_ena) begin
            ena_seen <= ena_seen + 1;
            if (ena_seen == 2) begin
                core_q     <= quot(ma, mb);
                model_busy <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (core_fdiv) fdiv_cnt <= fdiv_cnt + 1;
        if (core_ena)  ena_cnt  <= ena_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int fdiv0, ena0;

    // Drives one request; returns at the first negedge after the acceptance edge.
    task automatic start_op(input vec_t v);
        int n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.op_a = v.a; bus.op_b = v.b; bus.rm = v.rm; bus.in_valid = 1'b1;
        fdiv0 = fdiv_cnt; ena0 = ena_cnt;
        sb.push_back(v);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op_a = 32'hFFFF_FFFF; bus.op_b = 32'hFFFF_FFFF;
    endtask

    task automatic finish_op(input int n_start, input int exp_lat, input int hold);
        int n = n_start;
        vec_t e;
        logic [31:0] r0;
        logic [4:0]  f0;
        while (!bus.res_valid && n < 200) begin @(negedge clk); n++; end
        check("latency", n, exp_lat);
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard: result with no pending request");
            return;
        end
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("flags", {27'd0, bus.flags}, {27'd0, e.flg});
        check("fdiv_pulses", fdiv_cnt - fdiv0, e.special ? 0 : 1);
        check("ena_pulses", ena_cnt - ena0, e.special ? 0 : 3);
        r0 = bus.result; f0 = bus.flags;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_result", bus.result, r0);
            check("hold_flags", {27'd0, bus.flags}, {27'd0, f0});
            check("hold_valid", {31'd0, bus.res_valid}, 32'd1);
            check("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("post_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("post_res_valid", {31'd0, bus.res_valid}, 32'd0);
    endtask

    task automatic check_zeroed(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, "_res_valid"}, {31'd0, bus.res_valid}, 32'd0);
        check({tag, "_result"}, bus.result, 32'd0);
        check({tag, "_flags"}, {27'd0, bus.flags}, 32'd0);
        check({tag, "_core_fdiv"}, {31'd0, core_fdiv}, 32'd0);
        check({tag, "_core_ena"}, {31'd0, core_ena}, 32'd0);
        check({tag, "_core_ab"}, {8'd0, core_a | core_b}, 32'd0);
    endtask

    vec_t v63;

    initial begin
        fdiv_cnt = 0; ena_cnt = 0; busy_force = 1'b0;
        bus.in_valid = 1'b0; bus.op_a = 32'd0; bus.op_b = 32'd0; bus.rm = 2'b00;
        bus.res_ready = 1'b0;

        v63 = '{32'h40C0_0000, 32'h4040_0000, 2'b00, 32'h4000_0000, 5'h00, 1'b0};
        vt.push_back(v63);
        vt.push_back('{32'h3F80_0000, 32'h4040_0000, 2'b00, 32'h3EAA_AAAB, 5'h01, 1'b0});
        vt.push_back('{32'h4000_0000, 32'h4040_0000, 2'b00, 32'h3F2A_AAAB, 5'h01, 1'b0});
        vt.push_back('{32'h4040_0000, 32'h4000_0000, 2'b00, 32'h3FC0_0000, 5'h00, 1'b0});
        vt.push_back('{32'hBF80_0000, 32'h4000_0000, 2'b00, 32'hBF00_0000, 5'h00, 1'b0});
        vt.push_back('{32'hC0C0_0000, 32'h4040_0000, 2'b00, 32'hC000_0000, 5'h00, 1'b0});
        vt.push_back('{32'h7F7F_FFFF, 32'h3F80_0000, 2'b00, 32'h7F7F_FFFF, 5'h00, 1'b0});
        vt.push_back('{32'h7F00_0000, 32'h3E80_0000, 2'b00, 32'h7F80_0000, 5'h05, 1'b0});
        vt.push_back('{32'h7F7F_FFFF, 32'h3F00_0000, 2'b00, 32'h7F80_0000, 5'h05, 1'b0});
        vt.push_back('{32'h0080_0000, 32'h4000_0000, 2'b00, 32'h0000_0000, 5'h03, 1'b0});
        vt.push_back('{32'h8080_0000, 32'h4000_0000, 2'b00, 32'h8000_0000, 5'h03, 1'b0});
        vt.push_back('{32'h3F80_0000, 32'h0000_0000, 2'b00, 32'h7F80_0000, 5'h08, 1'b1});
        vt.push_back('{32'h3F80_0000, 32'h0040_0000, 2'b00, 32'h7F80_0000, 5'h08, 1'b1});
        vt.push_back('{32'h0000_0000, 32'h0000_0000, 2'b00, 32'h7FC0_0000, 5'h10, 1'b1});
        vt.push_back('{32'h7F80_0000, 32'h7F80_0000, 2'b00, 32'h7FC0_0000, 5'h10, 1'b1});
        vt.push_back('{32'h7FC0_0000, 32'h3F80_0000, 2'b00, 32'h7FC0_0000, 5'h00, 1'b1});
        vt.push_back('{32'h3F80_0000, 32'h7F80_0001, 2'b00, 32'h7FC0_0000, 5'h10, 1'b1});
        vt.push_back('{32'h3F80_0000, 32'h7F80_0000, 2'b00, 32'h0000_0000, 5'h00, 1'b1});
        vt.push_back('{32'hBF80_0000, 32'h7F80_0000, 2'b00, 32'h8000_0000, 5'h00, 1'b1});
        vt.push_back('{32'hFF80_0000, 32'h3F80_0000, 2'b00, 32'hFF80_0000, 5'h00, 1'b1});
        vt.push_back('{32'h7F80_0000, 32'h0000_0000, 2'b00, 32'h7F80_0000, 5'h00, 1'b1});
        vt.push_back('{32'h0040_0000, 32'h3F80_0000, 2'b00, 32'h0000_0000, 5'h00, 1'b1});
`ifdef FDIV_RMODE_EN
        vt.push_back('{32'h3F80_0000, 32'h4040_0000, 2'b01, 32'h3EAA_AAAA, 5'h01, 1'b0});
        vt.push_back('{32'hBF80_0000, 32'h4040_0000, 2'b10, 32'hBEAA_AAAB, 5'h01, 1'b0});
        vt.push_back('{32'hBF80_0000, 32'h4040_0000, 2'b11, 32'hBEAA_AAAA, 5'h01, 1'b0});
        vt.push_back('{32'h7F00_0000, 32'h3E80_0000, 2'b01, 32'h7F7F_FFFF, 5'h05, 1'b0});
        vt.push_back('{32'hFF00_0000, 32'h3E80_0000, 2'b11, 32'hFF7F_FFFF, 5'h05, 1'b0});
        vt.push_back('{32'hFF00_0000, 32'h3E80_0000, 2'b10, 32'hFF80_0000, 5'h05, 1'b0});
`else
        vt.push_back('{32'h3F80_0000, 32'h4040_0000, 2'b01, 32'h3EAA_AAAB, 5'h01, 1'b0});
        vt.push_back('{32'h7F00_0000, 32'h3E80_0000, 2'b01, 32'h7F80_0000, 5'h05, 1'b0});
`endif

        // Reset state
        #12;
        @(negedge clk);
        check_zeroed("reset");
        clrn = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        foreach (vt[i]) begin
            start_op(vt[i]);
            finish_op(1, vt[i].special ? 1 : 21, 0);
        end

        // Result held under back-pressure for 10 cycles
        start_op(v63);
        finish_op(1, 21, 10);

        // Core still busy: start pulse waits; cycle 0 becomes the one holding negedge 5
        busy_force = 1'b1;
        start_op(v63);
        repeat (4) @(negedge clk);
        check("no_fdiv_while_busy", fdiv_cnt - fdiv0, 0);
        busy_force = 1'b0;
        finish_op(5, 25, 0);

        // Reset in core cycle 8 abandons the division
        start_op(v63);
        repeat (8) @(negedge clk);
        clrn = 1'b0;
        #1;
        check_zeroed("midreset");
        sb.delete();
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("midreset_no_valid", {31'd0, bus.res_valid}, 32'd0);
        start_op(v63);
        finish_op(1, 21, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end
endmodule

// File: doc/fdiv_newton_ctrl.md
FDIV_NEWTON_CTRL -- requirements
Module: fdiv_newton_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  the single clock; clrn  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have ports: in_valid  in  1  operand request; in_ready  out  1  request accepted; op_a  in  32  IEEE-754 single dividend; op_b  in  32  IEEE-754 single divisor; rm  in  2  rounding mode (00 RNE, 01 RTZ, 10 RDN, 11 RUP).
REQ-003 SHALL have ports: res_valid  out  1  result available; res_ready  in  1  result consumed; result  out  32  IEEE-754 single quotient; flags  out  5  {NV,DZ,OF,UF,NX}.
REQ-004 SHALL have core ports: core_a  out  24  dividend mantissa .1xxx; core_b  out  24  divisor mantissa .1xxx; core_fdiv  out  1  start; core_ena  out  1  pipeline advance; core_q  in  32  quotient x.xxx with sticky in bit 0; core_busy  in  1  core iterating.

Function
REQ-005 SHALL run FSM IDLE, START, ITER, DRAIN, DONE; in_ready=1 only in IDLE.
REQ-006 SHALL on in_valid&in_ready capture operands and rm, unpack sign/exponent/fraction, set core_a={1,frac_a}, core_b={1,frac_b}, holding both stable until leaving DRAIN.
REQ-007 SHALL treat exponent 0 operands as zero (denormals flushed) and detect NaN/inf/zero specials at acceptance.
REQ-008 SHALL, for special cases, bypass the core: go IDLE->DONE with res_valid high the cycle after acceptance; x/0 (x finite nonzero) -> signed inf, DZ; 0/0 or inf/inf -> 0x7FC00000, NV; NaN operand -> 0x7FC00000, NV only if signaling; finite/inf -> signed zero; inf/finite -> signed inf.
REQ-009 SHALL in START assert core_fdiv for exactly one cycle, the first cycle with core_busy=0; that cycle is core cycle 0.
REQ-010 SHALL in ITER count core cycles 1..15 with a 5-bit counter, core_fdiv=0, core_ena=0.
REQ-011 SHALL in DRAIN assert core_ena during core cycles 16, 17, 18 exactly; core_q is valid in cycle 19.
REQ-012 SHALL in cycle 19 normalise and round core_q, register result/flags, enter DONE; res_valid high from cycle 20 (21 clocks after acceptance edge, excluding START wait).
REQ-013 SHALL compute biased exponent e=ea-eb+127 (10-bit signed); if core_q[31]=1 mantissa=core_q[31:8], guard=core_q[7], sticky=|core_q[6:0]; else mantissa=core_q[30:7], guard=core_q[6], sticky=|core_q[5:0], e=e-1.
REQ-014 SHALL round per selected mode, incrementing e on mantissa carry-out; NX=guard|sticky.
REQ-015 SHALL on e>=255 after rounding return inf (RNE/away-direction) or max finite 0x7F7FFFFF magnitude (toward-zero directions), set OF, NX.
REQ-016 SHALL on e<=0 return signed zero, set UF, NX (no denormal output).
REQ-017 SHALL sign result = sign_a XOR sign_b for all non-NaN results.
REQ-018 SHALL hold result, flags, res_valid stable in DONE until res_ready=1, then go IDLE; in_ready rises the cycle after.
REQ-019 SHALL ignore in_valid outside IDLE.

Reset
REQ-020 SHALL on clrn=0 immediately force IDLE; in_ready=0 during reset, 1 after; res_valid, core_fdiv, core_ena, result, flags, core_a, core_b, counter = 0.
REQ-021 SHALL on reset mid-operation abandon the division with no result; core shares clrn and restarts idle.

Configuration
REQ-022 SHALL, with FDIV_RMODE_EN defined, honour rm for all four modes; without it, ignore rm, use RNE only, and REQ-015 returns inf always.

Verification
REQ-023 op_a=0x40C00000 (6.0), op_b=0x40400000 (3.0) -> result 0x40000000, flags 0, res_valid 21 clocks after acceptance.
REQ-024 op_a=0x3F800000, op_b=0x40400000, rm=00 -> 0x3EAAAAAB, NX; with FDIV_RMODE_EN and rm=01 -> 0x3EAAAAAA, NX.
REQ-025 op_a=0x3F800000, op_b=0x00000000 -> 0x7F800000, DZ, res_valid next cycle, core_fdiv never asserted.
REQ-026 op_a=0x00000000, op_b=0x00000000 -> 0x7FC00000, NV; op_a=0x7F000000, op_b=0x3E800000 -> 0x7F800000, OF|NX.
REQ-027 res_ready held 0 for 10 cycles in DONE -> result/flags unchanged, in_ready=0 throughout; then res_ready=1 -> IDLE.
REQ-028 clrn pulsed low at core cycle 8 -> all outputs 0 immediately; next request 6.0/3.0 -> 0x40000000 with normal latency.
